// File: rtl/proc8085_pkg.sv
// Shared types and constants for the 8085 memory-bus responder and its byte RAM.
package proc8085_pkg;

    localparam int BUS_DW = 8;
    localparam int DEF_AW = 16;

    localparam logic [BUS_DW-1:0] RD_FAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    typedef struct packed {
        logic              we;
        logic [DEF_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port byte RAM: synchronous write and registered read, both gated by en.
module bus_mem_array
    import proc8085_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [BUS_DW-1:0] wdata,
    output logic [BUS_DW-1:0] rdata
);

    logic [BUS_DW-1:0] mem [0:DEPTH-1];

    // Plain always so that test harnesses can preload mem by hierarchical reference.
    always @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (en && !we) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder_8085.sv
// 8085 memory-bus responder: captures a byte request, waits WAIT_CYC cycles, then acks.
// Optional address fault reporting (err port) is compiled in with MEM_ADDR_CHECK_EN.
module mem_responder_8085
    import proc8085_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [BUS_DW-1:0] wdata,
    output logic [BUS_DW-1:0] rdata,
    output logic              ack,
    output logic              busy
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int IW = $clog2(DEPTH);

    if (AW > DEF_AW || DEPTH > (1 << AW) || (DEPTH & (DEPTH - 1)) != 0 ||
        WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_cfg
        $error("mem_responder_8085: unsupported parameter set");
    end

    resp_state_t       state;
    logic [3:0]        cnt;
    bus_req_t          req_q;
    bus_req_t          cur;
    logic              access;
    logic              in_range;
    logic              fault;
    logic              rd_seen;
    logic              rd_fault;
    logic [BUS_DW-1:0] ram_rdata;

    // In IDLE the zero-wait access must use the live bus, since req_q loads on the same edge.
    always_comb begin
        cur = req_q;
        if (state == IDLE) begin
            cur.we    = we;
            cur.addr  = DEF_AW'(addr);
            cur.wdata = wdata;
        end
    end

    assign access   = ((state == IDLE) && req && (WAIT_CYC == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));
    assign in_range = 32'(cur.addr) < DEPTH;

`ifdef MEM_ADDR_CHECK_EN
    assign fault = !in_range;
`else
    logic in_range_unused;
    assign in_range_unused = in_range;
    assign fault = 1'b0;
`endif

    bus_mem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .en    (access && !fault),
        .we    (cur.we),
        .idx   (cur.addr[IW-1:0]),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            req_q <= cur;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ack      <= 1'b0;
            rd_seen  <= 1'b0;
            rd_fault <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
            err      <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        if (WAIT_CYC == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYC - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (access) begin
                ack <= 1'b1;
`ifdef MEM_ADDR_CHECK_EN
                err <= fault;
`endif
                if (!cur.we) begin
                    rd_seen  <= 1'b1;
                    rd_fault <= fault;
                end
            end
        end
    end

    // rdata reads zero until the first read after reset, then holds the last read result.
    assign rdata = !rd_seen ? '0 : (rd_fault ? RD_FAULT : ram_rdata);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder_8085.sv
// Randomized bench for mem_responder_8085 against a latency-based transaction model.
module tb_mem_responder_8085;

    localparam int W     = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        busy;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    mem_responder_8085 #(
        .AW       (16),
        .DEPTH    (DEPTH),
        .WAIT_CYC (W)
    ) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy)
`ifdef MEM_ADDR_CHECK_EN
        ,
        .err   (err)
`endif
    );

`ifndef MEM_ADDR_CHECK_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a request accepted on edge n is serviced on edge n+W
    // (ack visible after it), and the responder accepts again from edge n+W+2.
    logic [7:0]  mm [DEPTH];
    bit          m_act;
    int          m_k;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wd;
    bit          e_ack;
    bit          e_busy;
    bit          e_err;
    logic [7:0]  e_rdata;

    function automatic bit oor(input logic [15:0] a);
`ifdef MEM_ADDR_CHECK_EN
        return int'(a) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_access();
        e_ack = 1'b1;
        e_err = oor(m_addr);
        if (m_we) begin
            if (!oor(m_addr)) mm[int'(m_addr) % DEPTH] = m_wd;
        end else begin
            e_rdata = oor(m_addr) ? 8'hFF : mm[int'(m_addr) % DEPTH];
        end
    endtask

    initial begin
        m_act = 1'b0; e_ack = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_rdata = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_act = 1'b0; e_ack = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_rdata = 8'h00;
            end else begin
                e_ack = 1'b0;
                e_err = 1'b0;
                if (m_act) begin
                    m_k++;
                    if (m_k == W) begin
                        m_access();
                    end else if (m_k == W + 1) begin
                        m_act  = 1'b0;
                        e_busy = 1'b0;
                    end
                end else if (req) begin
                    m_act  = 1'b1;
                    m_k    = 0;
                    e_busy = 1'b1;
                    m_we   = we;
                    m_addr = addr;
                    m_wd   = wdata;
                    if (W == 0) m_access();
                end
            end
        end
    end

    // Cycle-by-cycle comparison, sampled just after each rising edge.
    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1;
            chk("ack", 32'(ack), 32'(e_ack));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("rdata", 32'(rdata), 32'(e_rdata));
`ifdef MEM_ADDR_CHECK_EN
            chk("err", 32'(err), 32'(e_err));
`endif
        end
    end

    task automatic do_req(input logic w, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic e, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        chk("cap_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!ack && lat < 40) begin
            we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!ack) chk("ack_timeout", 32'd0, 32'd1);
        rd  = rdata;
        e   = err;
        req = 1'b0;
    endtask

    task automatic wait_ack(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 40);
        if (!ack) chk("ack_timeout", 32'd0, 32'd1);
        t = cyc;
    endtask

    initial begin
        logic [7:0] rd;
        logic       e;
        int         lat;
        int         t1;
        int         t2;
        logic [7:0] r1;
        logic [7:0] r2;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = 8'($urandom);
        end
        mm[0] = 8'h01; mm[1] = 8'h02; mm[3] = 8'h11; mm[5] = 8'h3C;
        for (int i = 0; i < DEPTH; i++) begin
            u_dut.u_mem.mem[i] = mm[i];
        end

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem5", 32'(u_dut.u_mem.mem[5]), 32'h3C);

        do_req(1'b0, 16'd5, 8'h00, rd, e, lat);
        chk("rd5_lat", 32'(lat), 32'(W));
        chk("rd5_data", 32'(rd), 32'h3C);
        @(negedge clk);
        chk("rd5_post_ack", 32'(ack), 32'd0);
        chk("rd5_post_busy", 32'(busy), 32'd0);

        do_req(1'b1, 16'd9, 8'hA5, rd, e, lat);
        chk("wr9_lat", 32'(lat), 32'(W));
        chk("wr9_rdata_hold", 32'(rd), 32'h3C);
        do_req(1'b0, 16'd9, 8'h00, rd, e, lat);
        chk("rd9_data", 32'(rd), 32'hA5);

        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'd0;
        wait_ack(t1);
        r1 = rdata;
        addr = 16'd1;
        wait_ack(t2);
        r2 = rdata;
        req = 1'b0;
        chk("b2b_spacing", 32'(t2 - t1), 32'(W + 2));
        chk("b2b_first", 32'(r1), 32'h01);
        chk("b2b_second", 32'(r2), 32'h02);

        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'd3; wdata = 8'h77;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        req = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_ack", 32'(ack), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_idle", 32'(busy), 32'd0);
        chk("mid_mem3", 32'(u_dut.u_mem.mem[3]), 32'h11);
        do_req(1'b0, 16'd3, 8'h00, rd, e, lat);
        chk("mid_rd3", 32'(rd), 32'h11);

`ifdef MEM_ADDR_CHECK_EN
        do_req(1'b0, 16'h0105, 8'h00, rd, e, lat);
        chk("oor_rd_err", 32'(e), 32'd1);
        chk("oor_rd_data", 32'(rd), 32'hFF);
        chk("oor_rd_lat", 32'(lat), 32'(W));
        do_req(1'b1, 16'h0105, 8'h99, rd, e, lat);
        chk("oor_wr_err", 32'(e), 32'd1);
        do_req(1'b0, 16'd5, 8'h00, rd, e, lat);
        chk("oor_mem5", 32'(rd), 32'h3C);
        chk("inrange_err", 32'(e), 32'd0);
`else
        do_req(1'b0, 16'h0105, 8'h00, rd, e, lat);
        chk("alias_rd", 32'(rd), 32'h3C);
        do_req(1'b1, 16'h0209, 8'h5A, rd, e, lat);
        do_req(1'b0, 16'd9, 8'h00, rd, e, lat);
        chk("alias_wr", 32'(rd), 32'h5A);
`endif

        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1023))
                                            : 16'($urandom_range(0, 15));
            do_req(1'($urandom), a, 8'($urandom), rd, e, lat);
            chk("rand_lat", 32'(lat), 32'(W));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
